// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path.
// Holds the frame layout, parity mode names and the round-robin grant search.
package uart_pkg;

  localparam int unsigned UART_DW = 8;
  localparam int unsigned MAX_CH  = 8;

  typedef struct packed {
    logic               pc_pass;
    logic [UART_DW-1:0] data;
  } rx_frame_t;

  localparam string PAR_NONE = "NONE";
  localparam string PAR_EVEN = "EVEN";
  localparam string PAR_ODD  = "ODD";

  // Returns {found, idx}: the first set req bit at or above ptr, wrapping mod n.
  function automatic logic [3:0] rr_next(input logic [MAX_CH-1:0] req,
                                         input logic [2:0]        ptr,
                                         input int unsigned       n);
    logic [3:0]  res;
    int unsigned idx;
    res = '0;
    // Scan from the far end so the smallest offset from ptr wins.
    for (int i = MAX_CH - 1; i >= 0; i--) begin
      idx = (32'(ptr) + 32'(i)) % n;
      if (32'(i) < n && req[idx[2:0]]) res = {1'b1, idx[2:0]};
    end
    return res;
  endfunction

endpackage

// File: rtl/uart_rx_chan_fifo.sv
// Per-channel frame FIFO with extra-MSB pointers.
// The caller guarantees push only when not full (or popped the same cycle) and pop only when not empty.
module uart_rx_chan_fifo #(
  parameter int W     = 9,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [W-1:0]  mem_q [DEPTH];

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (push) wr_d = wr_q + 1'b1;
    if (pop)  rd_d = rd_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Storage needs no reset: the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q[AW-1:0]] <= din;
  end

  assign dout  = mem_q[rd_q[AW-1:0]];
  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);

endmodule

// File: rtl/uart_rx_rr_arbiter.sv
// Merges NUM_CH receiver byte streams into one channel-tagged valid/ready stream.
// Each channel is buffered; a frame hitting a full FIFO is dropped and counted.
module uart_rx_rr_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_CH-1:0]            in_vld,
  input  logic [NUM_CH*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_CH-1:0]            in_pc_pass,
  output logic [NUM_CH-1:0]            in_rdy,
  output logic                         o_vld,
  output logic [DATA_WIDTH-1:0]        o_data,
  output logic [$clog2(NUM_CH)-1:0]    o_ch,
  output logic                         o_pc_pass,
  input  logic                         i_rdy,
  output logic [NUM_CH-1:0]            ovf,
  output logic [NUM_CH*CNT_W-1:0]      drop_cnt,
  input  logic                         clr_ovf
);
  localparam int CH_W = $clog2(NUM_CH);
  localparam int FW   = DATA_WIDTH + 1;

  logic [NUM_CH-1:0]         push, pop, full, empty, drop;
  logic [NUM_CH-1:0][FW-1:0] fifo_dout;

  logic                           rdy_q;
  logic                           o_vld_q, o_vld_d;
  logic [DATA_WIDTH-1:0]          o_data_q, o_data_d;
  logic [CH_W-1:0]                o_ch_q, o_ch_d;
  logic                           o_pc_q, o_pc_d;
  logic [CH_W-1:0]                rr_q, rr_d;
  logic [NUM_CH-1:0]              ovf_q, ovf_d;
  logic [NUM_CH-1:0][CNT_W-1:0]   cnt_q, cnt_d;

  logic [MAX_CH-1:0] req;
  logic [3:0]        rr_res;
  logic [CH_W-1:0]   gnt;
  logic              load;

  assign in_rdy = {NUM_CH{rdy_q}};

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    uart_rx_chan_fifo #(.W(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push[k]),
      .pop   (pop[k]),
      .din   ({in_pc_pass[k], in_data[k*DATA_WIDTH +: DATA_WIDTH]}),
      .dout  (fifo_dout[k]),
      .full  (full[k]),
      .empty (empty[k])
    );
  end

  // Scheduler and output register.
  always_comb begin
    req      = MAX_CH'(~empty);
    rr_res   = rr_next(req, 3'(rr_q), NUM_CH);
    gnt      = CH_W'(rr_res[2:0]);
    load     = !o_vld_q || i_rdy;
    pop      = '0;
    rr_d     = rr_q;
    o_vld_d  = o_vld_q;
    o_data_d = o_data_q;
    o_ch_d   = o_ch_q;
    o_pc_d   = o_pc_q;
    if (load) begin
      if (rr_res[3]) begin
        pop[gnt] = 1'b1;
        rr_d     = (gnt == CH_W'(NUM_CH - 1)) ? '0 : gnt + 1'b1;
        o_vld_d  = 1'b1;
        o_data_d = fifo_dout[gnt][DATA_WIDTH-1:0];
        o_pc_d   = fifo_dout[gnt][DATA_WIDTH];
        o_ch_d   = gnt;
      end else begin
        o_vld_d = 1'b0;
      end
    end
  end

  // Ingress and drop accounting; a same-cycle pop frees the slot for the push.
  always_comb begin
    ovf_d = ovf_q;
    cnt_d = cnt_q;
    if (clr_ovf) begin
      ovf_d = '0;
      cnt_d = '0;
    end
    for (int k = 0; k < NUM_CH; k++) begin
      push[k] = in_vld[k] && rdy_q && (!full[k] || pop[k]);
      drop[k] = in_vld[k] && rdy_q && full[k] && !pop[k];
      if (drop[k]) begin
        ovf_d[k] = 1'b1;
        if (cnt_d[k] != {CNT_W{1'b1}}) cnt_d[k] = cnt_d[k] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdy_q    <= 1'b0;
      o_vld_q  <= 1'b0;
      o_data_q <= '0;
      o_ch_q   <= '0;
      o_pc_q   <= 1'b0;
      rr_q     <= '0;
      ovf_q    <= '0;
      cnt_q    <= '0;
    end else begin
      rdy_q    <= 1'b1;
      o_vld_q  <= o_vld_d;
      o_data_q <= o_data_d;
      o_ch_q   <= o_ch_d;
      o_pc_q   <= o_pc_d;
      rr_q     <= rr_d;
      ovf_q    <= ovf_d;
      cnt_q    <= cnt_d;
    end
  end

  assign o_vld     = o_vld_q;
  assign o_data    = o_data_q;
  assign o_ch      = o_ch_q;
  assign o_pc_pass = o_pc_q;
  assign ovf       = ovf_q;
  assign drop_cnt  = cnt_q;

endmodule

// File: tb/tb_uart_rx_rr_arbiter.sv
// Directed bench for uart_rx_rr_arbiter with hand-computed expectations.
module tb_uart_rx_rr_arbiter;
  logic        clk, rst;
  logic [3:0]  in_vld, in_pc_pass, in_rdy, ovf;
  logic [31:0] in_data, drop_cnt;
  logic        o_vld, o_pc_pass, i_rdy, clr_ovf;
  logic [7:0]  o_data;
  logic [1:0]  o_ch;

  int total = 0;
  int bad   = 0;

  uart_rx_rr_arbiter #(.NUM_CH(4), .DATA_WIDTH(8), .FIFO_DEPTH(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_data(in_data), .in_pc_pass(in_pc_pass),
    .in_rdy(in_rdy), .o_vld(o_vld), .o_data(o_data), .o_ch(o_ch), .o_pc_pass(o_pc_pass),
    .i_rdy(i_rdy), .ovf(ovf), .drop_cnt(drop_cnt), .clr_ovf(clr_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] v, input logic [31:0] d, input logic [3:0] p);
    in_vld = v; in_data = d; in_pc_pass = p;
    tick();
    in_vld = '0; in_pc_pass = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_vld = '0; in_data = '0; in_pc_pass = '0; clr_ovf = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1; in_vld = '0; in_data = '0; in_pc_pass = '0; i_rdy = 1'b1; clr_ovf = 1'b0;
    tick();
    chk("rst_o_vld", 32'(o_vld), 0);
    chk("rst_o_data", 32'(o_data), 0);
    chk("rst_in_rdy", 32'(in_rdy), 0);
    chk("rst_ovf", 32'(ovf), 0);
    chk("rst_drop", drop_cnt, 0);
    rst = 1'b0;
    tick();
    chk("rdy_after_rst", 32'(in_rdy), 32'hF);

    // single frame on ch2
    send(4'b0100, 32'h00A5_0000, 4'b0100);
    chk("single_t1_vld", 32'(o_vld), 0);
    tick();
    chk("single_vld", 32'(o_vld), 1);
    chk("single_data", 32'(o_data), 32'hA5);
    chk("single_ch", 32'(o_ch), 2);
    chk("single_pc", 32'(o_pc_pass), 1);
    tick();
    chk("single_vld_off", 32'(o_vld), 0);

    // round robin from pointer 0
    do_reset();
    send(4'hF, 32'h1312_1110, 4'h0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rr0_vld", 32'(o_vld), 1);
      chk("rr0_ch", 32'(o_ch), 32'(i));
      chk("rr0_data", 32'(o_data), 32'h10 + 32'(i));
    end
    tick();
    chk("rr0_idle", 32'(o_vld), 0);
    // one frame on ch1 leaves the pointer at 2
    send(4'b0010, 32'h0000_5500, 4'h0);
    tick();
    chk("rr_ptr_ch", 32'(o_ch), 1);
    send(4'hF, 32'h1312_1110, 4'h0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rr2_ch", 32'(o_ch), 32'((i + 2) % 4));
      chk("rr2_data", 32'(o_data), 32'h10 + 32'((i + 2) % 4));
    end

    // backpressure on ch1
    do_reset();
    i_rdy = 1'b0;
    send(4'b0010, 32'h0000_2100, 4'h0);
    send(4'b0010, 32'h0000_2200, 4'h0);
    send(4'b0010, 32'h0000_2300, 4'h0);
    repeat (7) tick();
    chk("bp_vld", 32'(o_vld), 1);
    chk("bp_hold_data", 32'(o_data), 32'h21);
    chk("bp_hold_ch", 32'(o_ch), 1);
    i_rdy = 1'b1;
    tick();
    chk("bp_rel1", 32'(o_data), 32'h22);
    tick();
    chk("bp_rel2", 32'(o_data), 32'h23);
    tick();
    chk("bp_drain", 32'(o_vld), 0);
    chk("bp_nodrop", drop_cnt, 0);
    chk("bp_noovf", 32'(ovf), 0);

    // overflow on ch0
    do_reset();
    i_rdy = 1'b0;
    for (int k = 0; k < 6; k++) send(4'b0001, 32'h30 + 32'(k), 4'h0);
    chk("ovf_flag", 32'(ovf), 32'h1);
    chk("ovf_cnt", drop_cnt, 32'h1);
    chk("ovf_head", 32'(o_data), 32'h30);
    i_rdy = 1'b1;
    for (int k = 1; k < 5; k++) begin
      tick();
      chk("ovf_order", 32'(o_data), 32'h30 + 32'(k));
    end
    tick();
    chk("ovf_last_dropped", 32'(o_vld), 0);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    chk("clr_ovf", 32'(ovf), 0);
    chk("clr_cnt", drop_cnt, 0);

    // saturation on ch3: 5 frames accepted, the rest dropped
    i_rdy = 1'b0;
    in_vld = 4'b1000;
    repeat (260) tick();
    chk("sat_255", 32'(drop_cnt[31:24]), 255);
    repeat (45) tick();
    chk("sat_hold", 32'(drop_cnt[31:24]), 255);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    in_vld = '0;
    chk("clr_and_drop_cnt", 32'(drop_cnt[31:24]), 1);
    chk("clr_and_drop_ovf", 32'(ovf[3]), 1);

    // async reset while FIFOs hold data
    send(4'b0111, 32'h0042_4140, 4'h0);
    #2 rst = 1'b1;
    #1;
    chk("arst_vld", 32'(o_vld), 0);
    chk("arst_rdy", 32'(in_rdy), 0);
    @(posedge clk);
    #2 rst = 1'b0;
    i_rdy = 1'b1;
    tick();
    chk("arst_rdy_back", 32'(in_rdy), 32'hF);
    chk("arst_ovf", 32'(ovf), 0);
    chk("arst_cnt", drop_cnt, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("arst_no_stale", 32'(o_vld), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
